// File: rtl/filter_hit_extractor.sv
// filter_hit_extractor: turns first-filter bitmap beats into one (offset, bit) record per hit, plus an end-of-packet record
module filter_hit_extractor #(
  parameter int FP_DWIDTH = 128,
  parameter int OFF_WIDTH = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FP_DWIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OFF_WIDTH-1:0] out_pos,
  output logic [2:0]           out_tag,
  output logic                 out_eop,
  output logic                 overflow
);
  localparam int IW = $clog2(FP_DWIDTH);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, SCAN, EOP} state_t;
  state_t state, state_nx;
  logic [FP_DWIDTH-1:0] mem_data [BUF_DEPTH];
  logic [OFF_WIDTH-1:0] mem_base [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] mem_last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic [OFF_WIDTH-5:0] beat_cnt;
  logic push, pop, empty, adv, finish, use_rem, any;
  logic [FP_DWIDTH-1:0] rem, rem_nx, bits, onehot;
  logic [OFF_WIDTH-1:0] cur_base, cur_base_nx, base_sel, hit_pos, pos_nx;
  logic cur_last, cur_last_nx, ov_nx, eop_nx;
  logic [2:0] tag_nx;
  logic [IW-1:0] idx;
  assign push = in_valid && in_ready;
  assign empty = count == '0;
  assign adv = !out_valid || out_ready;
  assign count_nx = count + CW'(push) - CW'(pop);
  // rem holds hits not yet loaded into the output register; otherwise the FIFO head is scanned
  assign use_rem = (state == SCAN) && |rem;
  always_comb begin
    bits = use_rem ? rem : ~mem_data[rd_ptr];
    base_sel = use_rem ? cur_base : mem_base[rd_ptr];
    idx = '0;
    for (int k = FP_DWIDTH - 1; k >= 0; k--) if (bits[k]) idx = IW'(k);
  end
  assign any = |bits;
  assign onehot = {{(FP_DWIDTH-1){1'b0}}, 1'b1} << idx;
  assign hit_pos = base_sel + OFF_WIDTH'(idx >> 3);
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    finish = 1'b0;
    rem_nx = rem;
    cur_base_nx = cur_base;
    cur_last_nx = cur_last;
    ov_nx = out_valid;
    pos_nx = out_pos;
    tag_nx = out_tag;
    eop_nx = out_eop;
    case (state)
      IDLE: pop = !empty;
      SCAN: if (adv) begin
        if (use_rem) begin
          ov_nx = 1'b1;
          pos_nx = hit_pos;
          tag_nx = idx[2:0];
          eop_nx = 1'b0;
          rem_nx = bits & ~onehot;
        end else if (cur_last) begin
          state_nx = EOP;
          ov_nx = 1'b1;
          pos_nx = '0;
          tag_nx = '0;
          eop_nx = 1'b1;
        end else finish = 1'b1;
      end
      EOP: finish = out_ready;
      default: state_nx = IDLE;
    endcase
    if (finish) begin
      state_nx = IDLE;
      ov_nx = 1'b0;
      pos_nx = '0;
      tag_nx = '0;
      eop_nx = 1'b0;
      pop = !empty;
    end
    // popping loads the first hit straight into the output register, so there is no bubble
    if (pop) begin
      state_nx = SCAN;
      ov_nx = any;
      pos_nx = hit_pos;
      tag_nx = idx[2:0];
      eop_nx = 1'b0;
      rem_nx = bits & ~onehot;
      cur_base_nx = mem_base[rd_ptr];
      cur_last_nx = mem_last[rd_ptr];
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_base[wr_ptr] <= {beat_cnt, 4'b0000};
      mem_last[wr_ptr] <= in_last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_pos <= '0;
      out_tag <= '0;
      out_eop <= 1'b0;
      in_ready <= 1'b1;
      overflow <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat_cnt <= '0;
      rem <= '0;
      cur_base <= '0;
      cur_last <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= ov_nx;
      out_pos <= pos_nx;
      out_tag <= tag_nx;
      out_eop <= eop_nx;
      in_ready <= count_nx < CW'(BUF_DEPTH);
      overflow <= overflow || (in_valid && !in_ready);
      count <= count_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (in_valid) beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
      rem <= rem_nx;
      cur_base <= cur_base_nx;
      cur_last <= cur_last_nx;
    end
  end
endmodule

// File: tb/tb_filter_hit_extractor.sv
// tb_filter_hit_extractor: scoreboard bench with a per-hit reference model and randomized packets
module tb_filter_hit_extractor;
  localparam int FPW = 128;
  localparam int OW = 16;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [FPW-1:0] in_data = '1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_eop, overflow;
  logic [OW-1:0] out_pos;
  logic [2:0] out_tag;
  typedef struct packed {logic [OW-1:0] pos; logic [2:0] tag; logic eop;} rec_t;
  rec_t exp_q[$];
  int pkt_q[$];
  int pending = 0;
  int checks = 0;
  int errors = 0;
  int cnt_m = 0;
  bit rnd_ready = 1'b0;
  bit hold = 1'b0;
  rec_t prev;

  filter_hit_extractor #(.FP_DWIDTH(FPW), .OFF_WIDTH(OW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_tag(out_tag), .out_eop(out_eop), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // every 0 bit is a hit at byte offset beat*16 + i/8, bit i%8, in ascending order
  task automatic model_beat(input logic [FPW-1:0] d, input bit last, input bit acc);
    logic [OW-1:0] base;
    base = OW'(cnt_m * 16);
    if (acc) begin
      for (int i = 0; i < FPW; i++)
        if (!d[i]) exp_q.push_back('{pos: base + OW'(i / 8), tag: 3'(i % 8), eop: 1'b0});
      if (last) exp_q.push_back('{pos: '0, tag: '0, eop: 1'b1});
    end
    cnt_m = last ? 0 : cnt_m + 1;
  endtask

  task automatic send(input logic [FPW-1:0] d, input bit last, input bit acc);
    in_data = d;
    in_last = last;
    in_valid = 1'b1;
    model_beat(d, last, acc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  function automatic logic [FPW-1:0] rand_beat();
    logic [FPW-1:0] d;
    int mode;
    mode = $urandom_range(0, 3);
    for (int w = 0; w < FPW / 32; w++)
      d[w*32 +: 32] = mode == 0 ? 32'hffff_ffff :
                      mode == 1 ? ($urandom | $urandom | $urandom) :
                      mode == 2 ? ($urandom | $urandom | $urandom | $urandom | $urandom) : $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    rec_t e;
    if (!rst_n) hold = 1'b0;
    else begin
      if (out_valid && hold) chk("stable", {out_pos, out_tag, out_eop}, prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_record: got %0h expected none", {out_pos, out_tag, out_eop});
        end else begin
          e = exp_q.pop_front();
          chk("record", {out_pos, out_tag, out_eop}, e);
          if (out_eop && pkt_q.size() > 0) pending -= pkt_q.pop_front();
        end
      end
      hold = out_valid && !out_ready;
      prev = '{pos: out_pos, tag: out_tag, eop: out_eop};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FPW-1:0] d;
    int len, n;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pos", out_pos, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_out_eop", out_eop, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    d = '1; d[0] = 1'b0; d[17] = 1'b0;
    in_data = d; in_last = 1'b1; in_valid = 1'b1;
    model_beat(d, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("latency_c1", out_valid, 0);
    @(negedge clk);
    chk("latency_c2", out_valid, 1);
    @(posedge clk);
    #1;
    drain(50);
    send('1, 1'b0, 1'b1);
    d = '1; d[127] = 1'b0;
    send(d, 1'b1, 1'b1);
    d = '1; d[8] = 1'b0;
    send(d, 1'b1, 1'b1);
    drain(50);
    send('0, 1'b1, 1'b1);
    drain(300);
    d = '1; d[3] = 1'b0; d[4] = 1'b0; d[5] = 1'b0; d[40] = 1'b0; d[100] = 1'b0;
    send(d, 1'b1, 1'b1);
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    drain(50);
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 3);
      n = 0;
      while (pending + len > BD && n < 2000) begin
        tick();
        n++;
      end
      if (n == 2000) begin
        checks++;
        errors++;
        $display("FAIL credit_wait: pending %0d beats not retired after %0d cycles", pending, n);
        break;
      end
      pending += len;
      pkt_q.push_back(len);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        d = rand_beat();
        in_data = d;
        in_last = (b == len - 1);
        in_valid = 1'b1;
        chk("in_ready_rand", in_ready, 1);
        model_beat(d, b == len - 1, 1'b1);
        tick();
        in_valid = 1'b0;
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain(4000);
    chk("pending_retired", pending, 0);
    pkt_q.delete();
    out_ready = 1'b0;
    d = '1; d[0] = 1'b0;
    send(d, 1'b1, 1'b1);
    repeat (3) tick();
    for (int j = 0; j < 5; j++) begin
      d = '1; d[j*20+1] = 1'b0;
      in_data = d; in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready_fill", in_ready, j < 4);
      if (j == 4) chk("overflow_pre", overflow, 0);
      model_beat(d, 1'b1, j < 4);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("overflow_set", overflow, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain(100);
    chk("overflow_sticky", overflow, 1);
    chk("in_ready_after", in_ready, 1);
    send('1, 1'b0, 1'b1);
    send('0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_pos", out_pos, 0);
    chk("async_out_tag", out_tag, 0);
    chk("async_out_eop", out_eop, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_overflow", overflow, 0);
    exp_q.delete();
    pkt_q.delete();
    pending = 0;
    cnt_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    d = '1; d[5] = 1'b0;
    send(d, 1'b1, 1'b1);
    drain(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
